// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one clocked write port, r0 fixed at zero.
// Optional same-cycle write-through to the read ports when REGFILE_WRITE_BYPASS_EN is defined.
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  writeEn,
   input  logic [ADDR_WIDTH-1:0] writeAddr,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic [ADDR_WIDTH-1:0] readAddr1,
   input  logic [ADDR_WIDTH-1:0] readAddr2,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  writeValid;

   // Qualified write: reset wins, and r0 never takes a value.
   assign writeValid = writeEn && !rst && (writeAddr != '0);

   // Storage array with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs[i] <= '0;
         end
      end else if (writeValid) begin
         regs[writeAddr] <= writeData;
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   logic bypass1;
   logic bypass2;

   // Write-through removes the writeback-to-decode hazard.
   assign bypass1 = writeValid && (readAddr1 == writeAddr);
   assign bypass2 = writeValid && (readAddr2 == writeAddr);
`else
   logic bypass1;
   logic bypass2;

   assign bypass1 = 1'b0;
   assign bypass2 = 1'b0;
`endif

   // Read port 1: r0 forced to zero regardless of array contents.
   always_comb begin
      readData1 = regs[readAddr1];
      if (readAddr1 == '0) begin
         readData1 = '0;
      end else if (bypass1) begin
         readData1 = writeData;
      end
   end

   // Read port 2: identical to port 1, fully independent.
   always_comb begin
      readData2 = regs[readAddr2];
      if (readAddr2 == '0) begin
         readData2 = '0;
      end else if (bypass2) begin
         readData2 = writeData;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic against an array model.
module tb_register_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 6;
   localparam int unsigned DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          writeEn;
   logic [AW-1:0] writeAddr;
   logic [DW-1:0] writeData;
   logic [AW-1:0] readAddr1;
   logic [AW-1:0] readAddr2;
   logic [DW-1:0] readData1;
   logic [DW-1:0] readData2;

   logic [DW-1:0] model [DEPTH];
   int errors = 0;
   int checks = 0;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk),
      .rst(rst),
      .writeEn(writeEn),
      .writeAddr(writeAddr),
      .writeData(writeData),
      .readAddr1(readAddr1),
      .readAddr2(readAddr2),
      .readData1(readData1),
      .readData2(readData2)
   );

   always #5 clk = ~clk;

   // Expected read value from the architectural contents and the pending write.
   function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
      if (a == '0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (writeEn && !rst && a == writeAddr) return writeData;
`endif
      return model[a];
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs on the falling edge, then compare both read ports against the model.
   task automatic drive(input logic rs, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      @(negedge clk);
      rst = rs; writeEn = we; writeAddr = wa; writeData = wd;
      readAddr1 = r1; readAddr2 = r2;
      #1;
      check("model_rd1", readData1, expRead(r1));
      check("model_rd2", readData2, expRead(r2));
   endtask

   // Advance one rising edge and update the model from the spec's write/reset rules.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
      end else if (writeEn && writeAddr != '0) begin
         model[writeAddr] = writeData;
      end
   endtask

   initial begin
      rst = 1'b1; writeEn = 1'b0; writeAddr = '0; writeData = '0;
      readAddr1 = '0; readAddr2 = '0;
      tick();

      // All entries read zero after reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
         drive(1'b0, 1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i));
         check("reset_clear", readData1, 32'h0);
         tick();
      end

      drive(1'b0, 1'b1, 6'd5,  32'hAAAABBBB, 6'd1, 6'd2); tick();
      drive(1'b0, 1'b1, 6'd10, 32'h12345678, 6'd5, 6'd3); tick();
      drive(1'b0, 1'b1, 6'd15, 32'hDEADBEEF, 6'd10, 6'd5); tick();
      drive(1'b0, 1'b0, '0, '0, 6'd5, 6'd10);
      check("rd_5", readData1, 32'hAAAABBBB);
      check("rd_10", readData2, 32'h12345678);
      tick();
      drive(1'b0, 1'b0, '0, '0, 6'd15, 6'd0);
      check("rd_15", readData1, 32'hDEADBEEF);
      check("rd_0", readData2, 32'h0);
      tick();

      // Writes to r0 are discarded, including the same-cycle read.
      drive(1'b0, 1'b1, 6'd0, 32'hFFFFFFFF, 6'd0, 6'd0);
      check("r0_same_cycle", readData1, 32'h0);
      tick();
      drive(1'b0, 1'b0, '0, '0, 6'd0, 6'd15);
      check("r0_after", readData1, 32'h0);
      check("r15_kept", readData2, 32'hDEADBEEF);
      tick();

      drive(1'b1, 1'b0, '0, '0, 6'd5, 6'd10); tick();
      drive(1'b0, 1'b0, '0, '0, 6'd5, 6'd10);
      check("rst_5", readData1, 32'h0);
      check("rst_10", readData2, 32'h0);
      tick();

      // Reset beats a simultaneous write.
      drive(1'b1, 1'b1, 6'd7, 32'h11111111, 6'd7, 6'd7); tick();
      drive(1'b0, 1'b0, '0, '0, 6'd7, 6'd0);
      check("rst_prio_7", readData1, 32'h0);
      tick();

      drive(1'b0, 1'b1, 6'd20, 32'hCAFEF00D, 6'd0, 6'd0); tick();
      drive(1'b0, 1'b1, 6'd20, 32'h0BADBEEF, 6'd20, 6'd21);
`ifdef REGFILE_WRITE_BYPASS_EN
      check("same_cycle_20", readData1, 32'h0BADBEEF);
`else
      check("same_cycle_20", readData1, 32'hCAFEF00D);
`endif
      tick();
      drive(1'b0, 1'b0, '0, '0, 6'd20, 6'd20);
      check("after_edge_20", readData1, 32'h0BADBEEF);
      check("after_edge_20b", readData2, 32'h0BADBEEF);
      tick();

      // Random traffic; read addresses sometimes collide with the write address.
      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] wa;
         logic [AW-1:0] r1;
         logic [AW-1:0] r2;
         wa = AW'($urandom);
         r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
         r2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
         drive(($urandom_range(0, 40) == 0), 1'($urandom), wa, DW'($urandom), r1, r2);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Multi-ported general-purpose register file for the pipelined MIPS CPU datapath. It provides two independent combinational read ports, used by the decode stage, and one clocked write port, used by writeback. Register 0 is hardwired to zero. Synchronous reset clears every entry.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH entries (64 by default).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high; clears all registers.
- writeEn  input  1  write enable for the write port.
- writeAddr  input  ADDR_WIDTH  register written when writeEn=1.
- writeData  input  DATA_WIDTH  value written.
- readAddr1  input  ADDR_WIDTH  read port 1 address.
- readAddr2  input  ADDR_WIDTH  read port 2 address.
- readData1  output  DATA_WIDTH  contents of register readAddr1.
- readData2  output  DATA_WIDTH  contents of register readAddr2.

## Operation
- Storage is an array of 2**ADDR_WIDTH registers, each DATA_WIDTH bits.
- Write behaviour:
  - At the rising edge of clk, if rst=0, writeEn=1 and writeAddr!=0, then reg[writeAddr] takes writeData.
  - Writes to address 0 are discarded.
  - With writeEn=0, no register changes.
- Reset behaviour:
  - At the rising edge of clk, if rst=1, every register clears to 0.
  - Reset has priority over a simultaneous write; the write is lost.
- Read behaviour:
  - readDataN = reg[readAddrN]; the path is purely combinational with no clock involved.
  - Address 0 always reads 0.
- Both read ports are fully independent; they may read the same address or the write address at the same time.
- No other state exists and there is no FSM.

## Timing
- Write latency: data presented before edge k is visible on the read ports immediately after edge k.
- Read latency: 0 cycles; the output follows the address and the array contents combinationally.
- Reset: after the rising edge with rst=1, both outputs read 0 for every address, until a later write.
- Reset with no clock edge does nothing, because reset is synchronous.
- Same-cycle read of writeAddr while writeEn=1: without bypass, the output shows the old value until the edge (see Configuration).
- Read/write to address 0 in the same cycle: the read returns 0 in all configurations.
- X/undefined addresses are not required to be handled.

## Configuration
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when writeEn=1, rst=0, writeAddr!=0 and readAddrN==writeAddr, readDataN = writeData combinationally in the same cycle. This is a write-through that removes the writeback-to-decode hazard.
- Not defined: readDataN always reflects the stored array contents; a new value appears only after the write edge.

## Test plan
- Hold rst=1 for one edge, then release; read addresses 0..63 -> all read 00000000.
- Write 5=AAAABBBB, 10=12345678, 15=DEADBEEF, one per cycle, then writeEn=0:
  - read1=5, read2=10 -> AAAABBBB, 12345678.
  - read1=15, read2=0 -> DEADBEEF, 00000000.
- Write 0=FFFFFFFF with writeEn=1 -> reading 0 still returns 00000000.
- Assert rst=1 for one edge after the writes; read 5 and 10 -> 00000000, 00000000.
- Assert rst=1 and writeEn=1 (addr 7, data 11111111) on the same edge -> reg 7 reads 00000000 afterwards.
- With reg 20=CAFEF00D, write 20=0BADBEEF while read1=20, and sample before the edge:
  - With REGFILE_WRITE_BYPASS_EN -> 0BADBEEF.
  - Without it -> CAFEF00D.
  - After the edge, both configurations -> 0BADBEEF.
